// File: rtl/collision_score_feeder.sv
// Queues enemy-hit events and presents them to the score counter one point per frame,
// arming on the synchronized vsync falling edge and releasing on the rising edge.
module collision_score_feeder #(
  parameter int unsigned HIT_SOURCES = 4,
  parameter int unsigned PEND_W      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vsync,
  input  logic                   game_reset,
  input  logic [HIT_SOURCES-1:0] hit_valid,
  output logic                   enemy_collision,
  output logic                   credited,
  output logic [PEND_W-1:0]      pending,
  output logic                   overflow
);

  localparam int unsigned SumW = PEND_W + 3;
  localparam logic [SumW-1:0] PendMax = {3'b000, {PEND_W{1'b1}}};

  typedef enum logic {StIdle, StArmed} state_e;

  state_e            state;
  logic              vs_s1, vs_s2, vs_d;
  logic              vs_fall, vs_rise;
  logic [SumW-1:0]   inc, sum;
  logic              dec, sat;
  logic [PEND_W-1:0] pending_next;

  // Synchronizer survives game_reset so a restart mid-frame keeps edge tracking coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_s1 <= 1'b1;
      vs_s2 <= 1'b1;
      vs_d  <= 1'b1;
    end else begin
      vs_s1 <= vsync;
      vs_s2 <= vs_s1;
      vs_d  <= vs_s2;
    end
  end

  assign vs_fall = !vs_s2 && vs_d;
  assign vs_rise = vs_s2 && !vs_d;

  always_comb begin
    inc = '0;
    for (int i = 0; i < int'(HIT_SOURCES); i++) begin
      inc = inc + SumW'(hit_valid[i]);
    end
  end

  assign dec          = (state == StArmed) && vs_rise;
  assign sum          = SumW'(pending) + inc - SumW'(dec);
  assign sat          = sum > PendMax;
  assign pending_next = sat ? PendMax[PEND_W-1:0] : sum[PEND_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= StIdle;
      enemy_collision <= 1'b0;
      credited        <= 1'b0;
      pending         <= '0;
      overflow        <= 1'b0;
    end else if (game_reset) begin
      state           <= StIdle;
      enemy_collision <= 1'b0;
      credited        <= 1'b0;
      pending         <= '0;
      overflow        <= 1'b0;
    end else begin
      pending  <= pending_next;
      overflow <= overflow | sat;
      credited <= 1'b0;
      unique case (state)
        StIdle: begin
          // Arm only on the falling edge so the whole sync pulse is setup time.
          if (vs_fall && (pending != '0)) begin
            state           <= StArmed;
            enemy_collision <= 1'b1;
          end
        end
        StArmed: begin
          if (vs_rise) begin
            state           <= StIdle;
            enemy_collision <= 1'b0;
            credited        <= 1'b1;
          end
        end
        default: begin
          state           <= StIdle;
          enemy_collision <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_score_feeder.sv
// Self-checking bench for collision_score_feeder: directed scenarios plus randomized traffic
// compared against an integer-level model of the hit queue and frame credits.
module tb_collision_score_feeder;

  localparam int MaxPend = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       vsync;
  logic       game_reset;
  logic [3:0] hit_valid;
  logic       enemy_collision, credited, overflow;
  logic [3:0] pending;

  int passed = 0;
  int total  = 0;

  collision_score_feeder #(.HIT_SOURCES(4), .PEND_W(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .vsync           (vsync),
    .game_reset      (game_reset),
    .hit_valid       (hit_valid),
    .enemy_collision (enemy_collision),
    .credited        (credited),
    .pending         (pending),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: queue length as an integer, a frame edge is seen two edges after
  // vsync was first sampled at its new level.
  int m_pend;
  bit m_armed, m_ovf, m_cred;
  bit m_v1, m_v2, m_v3;
  wire m_fall = !m_v2 && m_v3;
  wire m_rise = m_v2 && !m_v3;
  wire m_give = m_armed && m_rise;
  int  m_total;
  assign m_total = m_pend + $countones(hit_valid) - (m_give ? 1 : 0);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend <= 0; m_armed <= 0; m_ovf <= 0; m_cred <= 0;
      m_v1 <= 1; m_v2 <= 1; m_v3 <= 1;
    end else begin
      m_v1 <= vsync; m_v2 <= m_v1; m_v3 <= m_v2;
      if (game_reset) begin
        m_pend <= 0; m_armed <= 0; m_ovf <= 0; m_cred <= 0;
      end else begin
        m_pend  <= (m_total > MaxPend) ? MaxPend : m_total;
        m_ovf   <= m_ovf || (m_total > MaxPend);
        m_cred  <= m_give;
        m_armed <= m_armed ? !m_rise : (m_fall && m_pend > 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_game_reset();
    game_reset = 1'b1; tick(); game_reset = 1'b0;
  endtask

  // One full frame: 4 cycles sync-low, 8 cycles high; reports what the counter would see.
  task automatic run_frame(output bit saw_ec, output int creds);
    saw_ec = 0; creds = 0;
    vsync = 1'b0;
    repeat (4) begin tick(); saw_ec |= enemy_collision; creds += int'(credited); end
    vsync = 1'b1;
    repeat (8) begin tick(); saw_ec |= enemy_collision; creds += int'(credited); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; vsync = 1'b1; game_reset = 1'b0; hit_valid = '0;
    #1;
    total++;
    if ({enemy_collision, credited, pending, overflow} !== 7'b0)
      $display("FAIL reset_outputs got ec=%b cr=%b p=%0d ov=%b want all 0",
               enemy_collision, credited, pending, overflow);
    else passed++;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    total++;
    if (enemy_collision !== 1'b0 || pending !== 4'd0)
      $display("FAIL post_reset_idle got ec=%b p=%0d want 0/0", enemy_collision, pending);
    else passed++;
  endtask

  task automatic test_single_hit();
    hit_valid = 4'b0001; tick(); hit_valid = '0;
    total++;
    if (pending !== 4'd1) $display("FAIL single_pend got %0d want 1", pending);
    else passed++;
    tick();
    vsync = 1'b0;
    tick(); tick();
    total++;
    if (enemy_collision !== 1'b0) $display("FAIL single_early_arm got %b want 0", enemy_collision);
    else passed++;
    tick();
    total++;
    if (enemy_collision !== 1'b1) $display("FAIL single_arm got %b want 1", enemy_collision);
    else passed++;
    tick();
    vsync = 1'b1;
    tick(); tick();
    total++;
    if (enemy_collision !== 1'b1 || credited !== 1'b0)
      $display("FAIL single_hold got ec=%b cr=%b want 1/0", enemy_collision, credited);
    else passed++;
    tick();
    total++;
    if (enemy_collision !== 1'b0 || credited !== 1'b1 || pending !== 4'd0)
      $display("FAIL single_release got ec=%b cr=%b p=%0d want 0/1/0",
               enemy_collision, credited, pending);
    else passed++;
    tick();
    total++;
    if (credited !== 1'b0) $display("FAIL single_credit_width got %b want 0", credited);
    else passed++;
  endtask

  task automatic test_burst();
    bit saw; int cr;
    hit_valid = 4'b1011; tick(); hit_valid = '0;
    total++;
    if (pending !== 4'd3) $display("FAIL burst_pend got %0d want 3", pending);
    else passed++;
    for (int f = 0; f < 4; f++) begin
      run_frame(saw, cr);
      total++;
      if (f < 3 && (saw !== 1'b1 || cr != 1 || pending !== 4'(2 - f)))
        $display("FAIL burst_frame%0d got ec=%b cr=%0d p=%0d want 1/1/%0d", f, saw, cr, pending, 2 - f);
      else if (f == 3 && (saw !== 1'b0 || cr != 0))
        $display("FAIL burst_frame3 got ec=%b cr=%0d want 0/0", saw, cr);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    bit saw; int cr;
    hit_valid = 4'b1111; repeat (5) tick(); hit_valid = '0;
    total++;
    if (pending !== 4'd15 || overflow !== 1'b1)
      $display("FAIL sat_fill got p=%0d ov=%b want 15/1", pending, overflow);
    else passed++;
    repeat (15) run_frame(saw, cr);
    total++;
    if (pending !== 4'd0 || overflow !== 1'b1)
      $display("FAIL sat_drain got p=%0d ov=%b want 0/1", pending, overflow);
    else passed++;
  endtask

  task automatic test_simultaneous();
    bit saw; int cr;
    pulse_game_reset();
    hit_valid = 4'b0011; tick(); hit_valid = '0;
    vsync = 1'b0; repeat (3) tick();
    total++;
    if (enemy_collision !== 1'b1 || pending !== 4'd2)
      $display("FAIL simul_armed got ec=%b p=%0d want 1/2", enemy_collision, pending);
    else passed++;
    tick();
    vsync = 1'b1; tick(); tick();
    hit_valid = 4'b0100; tick(); hit_valid = '0;
    total++;
    if (credited !== 1'b1 || pending !== 4'd2 || enemy_collision !== 1'b0)
      $display("FAIL simul_release got cr=%b p=%0d ec=%b want 1/2/0", credited, pending, enemy_collision);
    else passed++;
    tick();
    run_frame(saw, cr);
    total++;
    if (saw !== 1'b1 || cr != 1 || pending !== 4'd1)
      $display("FAIL simul_rearm got ec=%b cr=%0d p=%0d want 1/1/1", saw, cr, pending);
    else passed++;
  endtask

  task automatic test_game_reset();
    bit saw; int cr; int seen;
    pulse_game_reset();
    hit_valid = 4'b1111; repeat (4) tick(); hit_valid = '0;
    repeat (10) run_frame(saw, cr);
    vsync = 1'b0; repeat (3) tick();
    total++;
    if (enemy_collision !== 1'b1 || pending !== 4'd5 || overflow !== 1'b1)
      $display("FAIL grst_setup got ec=%b p=%0d ov=%b want 1/5/1", enemy_collision, pending, overflow);
    else passed++;
    hit_valid = 4'b0110;
    pulse_game_reset();
    hit_valid = '0;
    total++;
    if (enemy_collision !== 1'b0 || pending !== 4'd0 || overflow !== 1'b0 || credited !== 1'b0)
      $display("FAIL grst_clear got ec=%b p=%0d ov=%b cr=%b want 0/0/0/0",
               enemy_collision, pending, overflow, credited);
    else passed++;
    seen = 0;
    vsync = 1'b1;
    repeat (6) begin tick(); seen += int'(credited); end
    total++;
    if (seen != 0) $display("FAIL grst_no_credit got %0d pulses want 0", seen);
    else passed++;
  endtask

  task automatic test_async_reset();
    bit saw, any_ec; int cr;
    hit_valid = 4'b0001; tick(); hit_valid = '0;
    vsync = 1'b0; repeat (3) tick();
    total++;
    if (enemy_collision !== 1'b1) $display("FAIL areset_armed got %b want 1", enemy_collision);
    else passed++;
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({enemy_collision, credited, pending, overflow} !== 7'b0)
      $display("FAIL areset_immediate got ec=%b cr=%b p=%0d ov=%b want all 0",
               enemy_collision, credited, pending, overflow);
    else passed++;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    vsync = 1'b1;
    any_ec = 0;
    repeat (8) begin tick(); any_ec |= enemy_collision; end
    repeat (3) begin run_frame(saw, cr); any_ec |= saw; end
    total++;
    if (any_ec !== 1'b0 || pending !== 4'd0)
      $display("FAIL areset_quiet got ec_seen=%b p=%0d want 0/0", any_ec, pending);
    else passed++;
  endtask

  task automatic test_random();
    logic [6:0] exp_v, got_v;
    for (int c = 0; c < 1500; c++) begin
      exp_v = {m_armed, m_cred, 4'(m_pend), m_ovf};
      got_v = {enemy_collision, credited, pending, overflow};
      total++;
      if (got_v !== exp_v)
        $display("FAIL random_cycle%0d got ec/cr/p/ov=%b want %b", c, got_v, exp_v);
      else passed++;
      if ($urandom_range(0, 7) == 0) vsync = ~vsync;
      hit_valid  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      game_reset = ($urandom_range(0, 249) == 0);
      tick();
    end
    hit_valid = '0; game_reset = 1'b0; vsync = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_burst();
    test_saturation();
    test_simultaneous();
    test_game_reset();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
